mem_port_arbiter: RTL and testbench

Shares one single-port, fixed-latency SRAM between the IF stage (instruction fetch) and the MEM stage (data load/store) of the 5-stage pipeline. It sequences each multi-cycle access, captures read data, and produces the freeze signals that stall the pipeline while an access is pending. MEM-stage requests have priority because they belong to the older instruction.

---
 rtl/mem_port_arbiter_if.sv | 32 +++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and SRAM-side signals of the shared memory port arbiter.
interface mem_port_arbiter_if;
  logic        ifReq;
  logic [31:0] ifAddr;
  logic [31:0] ifData;
  logic        ifReady;
  logic        memRead;
  logic        memWrite;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic [31:0] memRData;
  logic        memReady;
  logic        freezeIf;
  logic        freezeMem;
  logic        sramEn;
  logic        sramWe;
  logic [31:0] sramAddr;
  logic [31:0] sramWData;
  logic [31:0] sramRData;

  modport slave (
    input  ifReq, ifAddr, memRead, memWrite, memAddr, memWData, sramRData,
    output ifData, ifReady, memRData, memReady, freezeIf, freezeMem,
           sramEn, sramWe, sramAddr, sramWData
  );

  modport master (
    output ifReq, ifAddr, memRead, memWrite, memAddr, memWData, sramRData,
    input  ifData, ifReady, memRData, memReady, freezeIf, freezeMem,
           sramEn, sramWe, sramAddr, sramWData
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency SRAM between IF and MEM; MEM wins ties. Each access
// takes WAIT_CYCLES busy cycles plus one done cycle; freezes stall the pipeline meanwhile.
module mem_port_arbiter #(
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_IF,
    BUSY_MEM,
    DONE_IF,
    DONE_MEM
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic [31:0] r_if_data;
  logic [31:0] r_mem_data;

  logic w_mem_req;
  logic w_busy;
  logic w_last;
  logic w_if_hit;

  assign w_mem_req = bus.memRead | bus.memWrite;
  assign w_busy    = (r_state == BUSY_IF) || (r_state == BUSY_MEM);
  assign w_last    = w_busy && (r_cnt == LAST_CNT);
  // A fetch only completes if IF still wants the same word (no redirect/flush).
  assign w_if_hit  = (r_state == DONE_IF) && bus.ifReq && (bus.ifAddr == r_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_we       <= 1'b0;
      r_if_data  <= 32'd0;
      r_mem_data <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_busy) begin
        r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
      end else begin
        r_cnt <= 4'd0;
      end
      if (r_state == IDLE) begin
        if (w_mem_req) begin
          r_addr  <= bus.memAddr;
          r_wdata <= bus.memWData;
          r_we    <= bus.memWrite;
        end else if (bus.ifReq) begin
          r_addr  <= bus.ifAddr;
          r_wdata <= 32'd0;
          r_we    <= 1'b0;
        end
      end
      if (w_last && (r_state == BUSY_IF)) begin
        r_if_data <= bus.sramRData;
      end
      if (w_last && (r_state == BUSY_MEM) && !r_we) begin
        r_mem_data <= bus.sramRData;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.sramEn    = 1'b0;
    bus.sramWe    = 1'b0;
    bus.sramAddr  = 32'd0;
    bus.sramWData = 32'd0;
    bus.memReady  = 1'b0;
    bus.ifReady   = w_if_hit;
    bus.ifData    = r_if_data;
    bus.memRData  = r_mem_data;
    bus.freezeMem = ~rst & w_mem_req & (r_state != DONE_MEM);
    bus.freezeIf  = ~rst & bus.ifReq & ~w_if_hit;

    unique case (r_state)
      IDLE: begin
        if (w_mem_req) begin
          w_state_nxt = BUSY_MEM;
        end else if (bus.ifReq) begin
          w_state_nxt = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_MEM: begin
        bus.sramEn    = 1'b1;
        bus.sramWe    = r_we;
        bus.sramAddr  = r_addr;
        bus.sramWData = r_wdata;
        if (w_last) begin
          w_state_nxt = (r_state == BUSY_IF) ? DONE_IF : DONE_MEM;
        end
      end
      DONE_IF: begin
        w_state_nxt = IDLE;
      end
      DONE_MEM: begin
        bus.memReady = 1'b1;
        w_state_nxt  = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, corner sequences, then random
// traffic against a transaction-phase reference model.
module tb_mem_port_arbiter;
  localparam int W = 3;
  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();
  mem_port_arbiter #(.WAIT_CYCLES(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] sram_mem [256];
  assign bus.sramRData = sram_mem[bus.sramAddr[9:2]];

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    logic r, fi; logic [31:0] ia;
    logic rd, wr; logic [31:0] ma, md;
    logic en, we; logic [31:0] sa, sw;
    logic ir, mr, fif, fm; logic [31:0] id, mdd;
  } vec_t;

  function automatic vec_t mk(input logic r, fi, input logic [31:0] ia,
                              input logic rd, wr, input logic [31:0] ma, md,
                              input logic en, we, input logic [31:0] sa, sw,
                              input logic ir, mr, fif, fm,
                              input logic [31:0] id, mdd);
    vec_t v;
    v.r = r; v.fi = fi; v.ia = ia; v.rd = rd; v.wr = wr; v.ma = ma; v.md = md;
    v.en = en; v.we = we; v.sa = sa; v.sw = sw;
    v.ir = ir; v.mr = mr; v.fif = fif; v.fm = fm; v.id = id; v.mdd = mdd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst          = v.r;
    bus.ifReq    = v.fi;
    bus.ifAddr   = v.ia;
    bus.memRead  = v.rd;
    bus.memWrite = v.wr;
    bus.memAddr  = v.ma;
    bus.memWData = v.md;
  endtask

  task automatic check_out(input vec_t v, input string tag);
    chk({tag, ".sramEn"},    32'(bus.sramEn),    32'(v.en));
    chk({tag, ".sramWe"},    32'(bus.sramWe),    32'(v.we));
    chk({tag, ".sramAddr"},  bus.sramAddr,       v.sa);
    chk({tag, ".sramWData"}, bus.sramWData,      v.sw);
    chk({tag, ".ifReady"},   32'(bus.ifReady),   32'(v.ir));
    chk({tag, ".memReady"},  32'(bus.memReady),  32'(v.mr));
    chk({tag, ".freezeIf"},  32'(bus.freezeIf),  32'(v.fif));
    chk({tag, ".freezeMem"}, 32'(bus.freezeMem), 32'(v.fm));
    chk({tag, ".ifData"},    bus.ifData,         v.id);
    chk({tag, ".memRData"},  bus.memRData,       v.mdd);
  endtask

  task automatic apply(input vec_t v, input string tag);
    drive(v);
    @(negedge clk);
    check_out(v, tag);
    @(posedge clk);
    #1;
  endtask

  vec_t tab[$];

  // Reference model state: one outstanding transaction and its phase (1..W busy, W+1 done).
  logic        m_act, m_mem, m_we;
  logic [31:0] m_addr, m_wd, m_ifd, m_memd;
  int          m_ph;

  initial begin
    logic [31:0] pick [4];
    vec_t v;
    logic e_done;
    pick[0] = 32'h40; pick[1] = 32'h44; pick[2] = 32'h80; pick[3] = 32'h3FC;

    for (int k = 0; k < 256; k++) sram_mem[k] = 32'hA5000000 ^ (32'(k) * 32'h00010203);
    sram_mem[16] = 32'hE3A00005;
    sram_mem[32] = 32'hCAFEF00D;
    sram_mem[64] = 32'h12345678;
    sram_mem[65] = 32'h0BADC0DE;

    drive(mk(H, L, 32'h0, L, L, 32'h0, 32'h0, L, L, 32'h0, 32'h0, L, L, L, L, 32'h0, 32'h0));
    @(posedge clk);
    #1;

    // Reset held with ifReq high
    tab.push_back(mk(H, H, 32'h40, L, L, 32'h0, 32'h0, L, L, 32'h0, 32'h0, L, L, L, L, 32'h0, 32'h0));
    tab.push_back(mk(H, H, 32'h40, L, L, 32'h0, 32'h0, L, L, 32'h0, 32'h0, L, L, L, L, 32'h0, 32'h0));
    // IF fetch at 0x40
    tab.push_back(mk(L, H, 32'h40, L, L, 32'h0, 32'h0, L, L, 32'h0, 32'h0, L, L, H, L, 32'h0, 32'h0));
    for (int c = 1; c <= 3; c++)
      tab.push_back(mk(L, H, 32'h40, L, L, 32'h0, 32'h0, H, L, 32'h40, 32'h0, L, L, H, L, 32'h0, 32'h0));
    tab.push_back(mk(L, H, 32'h40, L, L, 32'h0, 32'h0, L, L, 32'h0, 32'h0, H, L, L, L, 32'hE3A00005, 32'h0));
    tab.push_back(mk(L, L, 32'h40, L, L, 32'h0, 32'h0, L, L, 32'h0, 32'h0, L, L, L, L, 32'hE3A00005, 32'h0));
    // IF/MEM conflict: MEM load served first
    tab.push_back(mk(L, H, 32'h40, H, L, 32'h100, 32'h0, L, L, 32'h0, 32'h0, L, L, H, H, 32'hE3A00005, 32'h0));
    for (int c = 1; c <= 3; c++)
      tab.push_back(mk(L, H, 32'h40, H, L, 32'h100, 32'h0, H, L, 32'h100, 32'h0, L, L, H, H, 32'hE3A00005, 32'h0));
    tab.push_back(mk(L, H, 32'h40, H, L, 32'h100, 32'h0, L, L, 32'h0, 32'h0, L, H, H, L, 32'hE3A00005, 32'h12345678));
    tab.push_back(mk(L, H, 32'h40, L, L, 32'h0, 32'h0, L, L, 32'h0, 32'h0, L, L, H, L, 32'hE3A00005, 32'h12345678));
    for (int c = 6; c <= 8; c++)
      tab.push_back(mk(L, H, 32'h40, L, L, 32'h0, 32'h0, H, L, 32'h40, 32'h0, L, L, H, L, 32'hE3A00005, 32'h12345678));
    tab.push_back(mk(L, H, 32'h40, L, L, 32'h0, 32'h0, L, L, 32'h0, 32'h0, H, L, L, L, 32'hE3A00005, 32'h12345678));
    tab.push_back(mk(L, L, 32'h40, L, L, 32'h0, 32'h0, L, L, 32'h0, 32'h0, L, L, L, L, 32'hE3A00005, 32'h12345678));

    foreach (tab[i]) apply(tab[i], $sformatf("tab%0d", i));

    // Store: write data held through busy, memRData untouched
    for (int c = 0; c <= 5; c++) begin
      logic b;
      b = (c >= 1) && (c <= 3);
      apply(mk(L, L, 32'h40, L, logic'(c <= 4), 32'h200, 32'hDEADBEEF,
               b, b, b ? 32'h200 : 32'h0, b ? 32'hDEADBEEF : 32'h0,
               L, logic'(c == 4), L, logic'(c <= 3), 32'hE3A00005, 32'h12345678),
            $sformatf("store%0d", c));
    end

    // Redirect during fetch: stale word dropped, new address refetched
    for (int c = 0; c <= 10; c++) begin
      logic b1, b2, fi, ir;
      b1 = (c >= 1) && (c <= 3);
      b2 = (c >= 6) && (c <= 8);
      fi = (c <= 9);
      ir = (c == 9);
      apply(mk(L, fi, (c < 2) ? 32'h40 : 32'h80, L, L, 32'h0, 32'h0,
               b1 | b2, L, b1 ? 32'h40 : (b2 ? 32'h80 : 32'h0), 32'h0,
               ir, L, fi & ~ir, L, (c >= 9) ? 32'hCAFEF00D : 32'hE3A00005, 32'h12345678),
            $sformatf("redir%0d", c));
    end

    // Reset during a MEM access, then a fresh load completes
    for (int c = 0; c <= 8; c++) begin
      logic b, r, rd, mr;
      b  = (c == 1) || (c == 2) || ((c >= 4) && (c <= 6));
      r  = (c == 2);
      rd = (c <= 7);
      mr = (c == 7);
      apply(mk(r, L, 32'h80, rd, L, 32'h104, 32'h0,
               b, L, b ? 32'h104 : 32'h0, 32'h0,
               L, mr, L, rd & ~r & ~mr,
               (c <= 2) ? 32'hCAFEF00D : 32'h0,
               (c <= 2) ? 32'h12345678 : ((c >= 7) ? 32'h0BADC0DE : 32'h0)),
            $sformatf("mrst%0d", c));
    end

    m_act = 1'b0; m_mem = 1'b0; m_we = 1'b0; m_ph = 0;
    m_addr = 32'h0; m_wd = 32'h0; m_ifd = 32'h0; m_memd = 32'h0BADC0DE;
    v = mk(L, L, 32'h40, L, L, 32'h0, 32'h0, L, L, 32'h0, 32'h0, L, L, L, L, 32'h0, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      v.r  = ($urandom_range(63) == 0);
      if ($urandom_range(7) == 0) v.ia = pick[$urandom_range(3)];
      v.fi = ($urandom_range(3) != 0);
      v.rd = ($urandom_range(3) == 0);
      v.wr = ($urandom_range(4) == 0);
      v.ma = 32'($urandom_range(255)) << 2;
      v.md = $urandom;
      drive(v);
      @(negedge clk);

      v.en   = m_act && (m_ph <= W);
      v.we   = v.en && m_we;
      v.sa   = v.en ? m_addr : 32'h0;
      v.sw   = v.en ? m_wd : 32'h0;
      e_done = m_act && (m_ph == W + 1);
      v.mr   = e_done && m_mem;
      v.ir   = e_done && !m_mem && v.fi && (v.ia == m_addr);
      v.fm   = !v.r && (v.rd | v.wr) && !v.mr;
      v.fif  = !v.r && v.fi && !v.ir;
      v.id   = m_ifd;
      v.mdd  = m_memd;
      check_out(v, $sformatf("rnd%0d", i));

      if (v.r) begin
        m_act = 1'b0; m_ifd = 32'h0; m_memd = 32'h0;
      end else if (!m_act) begin
        if (v.rd | v.wr) begin
          m_act = 1'b1; m_mem = 1'b1; m_addr = v.ma; m_wd = v.md; m_we = v.wr; m_ph = 1;
        end else if (v.fi) begin
          m_act = 1'b1; m_mem = 1'b0; m_addr = v.ia; m_wd = 32'h0; m_we = 1'b0; m_ph = 1;
        end
      end else begin
        if (m_ph == W) begin
          if (!m_mem) m_ifd = sram_mem[m_addr[9:2]];
          else if (!m_we) m_memd = sram_mem[m_addr[9:2]];
        end
        if (m_ph == W + 1) m_act = 1'b0;
        else m_ph = m_ph + 1;
      end
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
